// File: rtl/rope_oscillator.sv
// Back-and-forth position generator for ropes, vines and platforms around an anchor point.
// Optional collision freeze: define ROPE_OSC_COLLISION_FREEZE_EN.
module rope_oscillator #(
    parameter int INITIAL_X    = 280,
    parameter int INITIAL_Y    = 185,
    parameter int AXIS         = 0,
    parameter int SPEED        = 20,
    parameter int DISTANCE     = 10,
    parameter int DWELL_FRAMES = 4,
    parameter int START_DIR    = 0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               direction,
    output logic               atEdge,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DWELL = 2'd2} state_t;

    localparam int BOUND  = DISTANCE * 64;
    localparam int DW     = (DWELL_FRAMES > 0) ? $clog2(DWELL_FRAMES + 1) : 1;
    localparam int ANCHOR = (AXIS == 0) ? INITIAL_X : INITIAL_Y;

    state_t             state_q, resume_q;
    logic signed [31:0] offset_q, step_d, offset_d;
    logic signed [10:0] pos_q, pos_d;
    logic               dir_q, at_edge_q;
    logic [DW-1:0]      dwell_q;
    logic               hit_pos_d, hit_neg_d;
    logic               frame_raw, frame_d, freeze_d;

    // A frame is "consumed" whenever it arrives while active, even if a freeze swallows it.
    assign frame_raw = startOfFrame & enable & (state_q != IDLE);
    assign frame_d   = frame_raw & ~freeze_d;

`ifdef ROPE_OSC_COLLISION_FREEZE_EN
    logic freeze_q;
    assign freeze_d = freeze_q | collision;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)        freeze_q <= 1'b0;
        else if (frame_raw) freeze_q <= 1'b0;
        else if (collision) freeze_q <= 1'b1;
    end
`else
    logic unused_collision;
    assign unused_collision = collision;
    assign freeze_d         = 1'b0;
`endif

    // Endpoints clamp exactly so travel never depends on SPEED dividing the bound.
    always_comb begin
        step_d    = dir_q ? (offset_q - SPEED) : (offset_q + SPEED);
        hit_pos_d = (step_d >= BOUND);
        hit_neg_d = (step_d <= -BOUND);
        offset_d  = hit_pos_d ? BOUND : (hit_neg_d ? -BOUND : step_d);
        pos_d     = 11'(ANCHOR + (offset_d >>> 6));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            resume_q  <= MOVE;
            offset_q  <= '0;
            dir_q     <= 1'(START_DIR);
            dwell_q   <= '0;
            at_edge_q <= 1'b0;
            pos_q     <= 11'(ANCHOR);
        end else begin
            at_edge_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= resume_q;
                end
                MOVE: begin
                    if (!enable) begin
                        state_q  <= IDLE;
                        resume_q <= MOVE;
                    end else if (frame_d && (BOUND != 0)) begin
                        offset_q <= offset_d;
                        pos_q    <= pos_d;
                        if (hit_pos_d || hit_neg_d) begin
                            dir_q     <= hit_pos_d;
                            at_edge_q <= 1'b1;
                            dwell_q   <= DW'(DWELL_FRAMES);
                            if (DWELL_FRAMES > 0) state_q <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (!enable) begin
                        state_q  <= IDLE;
                        resume_q <= DWELL;
                    end else if (frame_d) begin
                        dwell_q <= dwell_q - DW'(1);
                        if (dwell_q <= DW'(1)) state_q <= MOVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign topLeftX  = (AXIS == 0) ? pos_q : 11'(INITIAL_X);
    assign topLeftY  = (AXIS == 0) ? 11'(INITIAL_Y) : pos_q;
    assign direction = dir_q;
    assign atEdge    = at_edge_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rope_oscillator.sv
// Directed bench for rope_oscillator: four parameterisations share one stimulus stream.
// Handshake: startOfFrame is a one-clk pulse driven on the falling edge; outputs are read on the next falling edge.
module tb_rope_oscillator;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic en = 1'b0;
    logic col = 1'b0;

    always #5 clk = ~clk;

    logic signed [10:0] x0, y0, x1, y1, x2, y2, x3, y3;
    logic d0, d1, d2, d3, e0, e1, e2, e3;
    logic [1:0] s0, s1, s2, s3;

    rope_oscillator dut0 (.clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .collision(col),
        .topLeftX(x0), .topLeftY(y0), .direction(d0), .atEdge(e0), .state_o(s0));
    rope_oscillator #(.SPEED(300)) dut1 (.clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
        .collision(col), .topLeftX(x1), .topLeftY(y1), .direction(d1), .atEdge(e1), .state_o(s1));
    rope_oscillator #(.AXIS(1), .START_DIR(1)) dut2 (.clk(clk), .resetN(resetN), .startOfFrame(sof),
        .enable(en), .collision(col), .topLeftX(x2), .topLeftY(y2), .direction(d2), .atEdge(e2),
        .state_o(s2));
    rope_oscillator #(.DISTANCE(0)) dut3 (.clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en),
        .collision(col), .topLeftX(x3), .topLeftY(y3), .direction(d3), .atEdge(e3), .state_o(s3));

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int edge0 = 0, edge1 = 0, edge2 = 0, edge3 = 0;

    always @(negedge clk) begin
        if (e0) edge0 <= edge0 + 1;
        if (e1) edge1 <= edge1 + 1;
        if (e2) edge2 <= edge2 + 1;
        if (e3) edge3 <= edge3 + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    // Default-configuration frame whose expected X was queued before driving it.
    task automatic frame_x0(input string tag);
        frame();
        chk(tag, x0, exp_q.pop_front());
    endtask

    initial begin
        bit freeze_build;
`ifdef ROPE_OSC_COLLISION_FREEZE_EN
        freeze_build = 1'b1;
`else
        freeze_build = 1'b0;
`endif
        // Reset values
        idle(2);
        chk("rst_x0", x0, 280);
        chk("rst_y0", y0, 185);
        chk("rst_dir0", d0, 0);
        chk("rst_edge0", e0, 0);
        chk("rst_state0", s0, 0);
        chk("rst_dir2", d2, 1);
        chk("rst_y2", y2, 185);
        resetN = 1'b1;
        en = 1'b1;
        idle(2);
        chk("move_state0", s0, 1);

        // 32 frames of travel to the positive endpoint
        for (int n = 1; n <= 32; n++) begin
            exp_q.push_back(280 + (20 * n) / 64);
            frame_x0("travel_x0");
            chk("travel_y2", y2, 185 - ((20 * n + 63) / 64));
            chk("travel_x2", x2, 280);
            chk("still_x3", x3, 280);
            chk("still_y3", y3, 185);
            if (n == 1) chk("fast_f1_x1", x1, 284);
            if (n == 2) chk("fast_f2_x1", x1, 289);
            if (n == 3) chk("fast_f3_x1", x1, 290);
            if (n == 32) begin
                chk("edge_pulse0", e0, 1);
                chk("edge_dir0", d0, 1);
                chk("dwell_state0", s0, 2);
                chk("edge_dir2", d2, 0);
                idle(1);
                chk("edge_clear0", e0, 0);
            end
            idle(2);
        end
        chk("edge_count0", edge0, 1);
        chk("edge_count1", edge1, 4);
        chk("edge_count2", edge2, 1);

        // Dwell frames 33-36, then first step back on frame 37
        for (int n = 33; n <= 37; n++) begin
            exp_q.push_back((n == 37) ? 289 : 290);
            frame_x0("dwell_x0");
            chk("dwell_y2", y2, 175);
            idle(2);
        end

        // Enable falls in the same cycle as startOfFrame, then 10 frames disabled
        @(negedge clk);
        en = 1'b0;
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        chk("en_wins_x0", x0, 289);
        for (int n = 0; n < 10; n++) begin
            frame();
            idle(2);
        end
        chk("hold_x0", x0, 289);
        chk("hold_dir0", d0, 1);
        chk("hold_state0", s0, 0);
        en = 1'b1;
        idle(2);
        exp_q.push_back(289);
        exp_q.push_back(289);
        exp_q.push_back(288);
        for (int n = 0; n < 3; n++) begin
            frame_x0("resume_x0");
            idle(2);
        end

        // Stationary configuration keeps running well past 100 frames in total
        for (int n = 0; n < 50; n++) begin
            frame();
            chk("long_x3", x3, 280);
            idle(2);
        end
        chk("edge_count3", edge3, 0);
        chk("long_y3", y3, 185);

        // Asynchronous reset mid-motion takes effect before the next clock edge
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("arst_x0", x0, 280);
        chk("arst_dir0", d0, 0);
        chk("arst_y2", y2, 185);
        chk("arst_dir2", d2, 1);
        chk("arst_state0", s0, 0);
        @(negedge clk);
        resetN = 1'b1;
        idle(2);

        // Collision pulse between frames 5 and 6
        for (int n = 1; n <= 5; n++) begin
            exp_q.push_back(280 + (20 * n) / 64);
            frame_x0("pre_col_x0");
            idle(2);
        end
        @(negedge clk);
        col = 1'b1;
        @(negedge clk);
        col = 1'b0;
        exp_q.push_back(281);
        exp_q.push_back(freeze_build ? 281 : 282);
        exp_q.push_back(282);
        frame_x0("col_f6_x0");
        idle(2);
        frame_x0("col_f7_x0");
        idle(2);
        frame_x0("col_f8_x0");
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
